uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter that sits directly downstream of the HID report printer.
- Accepts bytes through a valid/ready push port into a power-of-two FIFO and serialises them LSB-first on uart_tx.
- Decouples the printer's bursty per-character writes from the slow serial line. The printer stalls on din_ready instead of timing its writes to the baud rate.
- Reports FIFO level, line activity, and a sticky overflow flag for debug.

---
 rtl/uart_tx_fifo_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_fifo_if : valid/ready byte push channel into uart_tx_fifo     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface uart_tx_fifo_if;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_fifo : FIFO-buffered 8N1 UART transmitter, LSB first          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200,
   parameter int DEPTH    = 16
) (
   input  wire                      clk,
   input  wire                      reset,
   uart_tx_fifo_if.slave            push,
   output logic                     uart_tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int PW  = $clog2(DEPTH);
   localparam int LW  = PW + 1;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e         state_q;
   logic [7:0]     mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [LW-1:0]  level_q;
   logic [LW-1:0]  level_d;
   logic [CW-1:0]  baud_q;
   logic [2:0]     bit_q;
   logic [7:0]     shift_q;
   logic           tx_q;
   logic           ovf_q;

   logic           fifo_empty;
   logic           fifo_ready;
   logic           baud_wrap;
   logic           do_push;
   logic           do_pop;
   logic [7:0]     head;

   // Ready depends only on the registered level, so a same-cycle pop never frees a slot early.
   assign fifo_empty = (level_q == '0);
   assign fifo_ready = (level_q != LVL_FULL);
   assign baud_wrap  = (baud_q == CNT_LAST);
   assign do_push    = push.din_valid & fifo_ready;
   assign do_pop     = ~fifo_empty &
                       ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_wrap));
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      if (do_push & ~do_pop) begin
         level_d = level_q + 1'b1;
      end else if (do_pop & ~do_push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push.din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         level_q <= level_d;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push.din_valid & ~fifo_ready) begin
            ovf_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         baud_q <= ((state_q == S_IDLE) | baud_wrap) ? '0 : baud_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (!fifo_empty) begin
                  shift_q <= head;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_wrap) begin
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_wrap) begin
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 1'b1;
                  end
               end
            end
            S_STOP: begin
               // Chain straight into the next start bit when data is waiting.
               if (baud_wrap) begin
                  if (!fifo_empty) begin
                     shift_q <= head;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign push.din_ready = fifo_ready;
   assign uart_tx        = tx_q;
   assign busy           = (state_q != S_IDLE) | ~fifo_empty;
   assign level          = level_q;
   assign overflow       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed + randomized bench against a timeline model|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_uart_tx_fifo;
   localparam int CLK_FREQ = 12000000;
   localparam int BAUD     = 115200;
   localparam int DEPTH    = 16;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_tx;
   logic       busy;
   logic       overflow;
   logic [4:0] level;

   uart_tx_fifo_if push_if ();

   uart_tx_fifo #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD),
      .DEPTH   (DEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .push    (push_if),
      .uart_tx (uart_tx),
      .busy    (busy),
      .level   (level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;

   // Model: queue of waiting bytes plus cycles left in the frame on the wire.
   logic [7:0] m_q[$];
   int         m_rem = 0;
   logic [7:0] m_cur = '0;
   logic       m_ovf = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int sz;
      sz = m_q.size();
      if (reset) begin
         m_q.delete();
         m_rem = 0;
         m_ovf = 1'b0;
      end else begin
         if (push_if.din_valid && sz == DEPTH) m_ovf = 1'b1;
         if (m_rem <= 1 && sz > 0) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (push_if.din_valid && sz < DEPTH) m_q.push_back(push_if.din);
      end
   endtask

   function automatic logic exp_tx();
      int idx;
      if (m_rem == 0) return 1'b1;
      idx = (FRAME - m_rem) / DIV;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[idx-1];
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_val("uart_tx",   uart_tx,           exp_tx());
      check_val("level",     level,             m_q.size());
      check_val("din_ready", push_if.din_ready, m_q.size() < DEPTH);
      check_val("busy",      busy,              (m_rem > 0) || (m_q.size() > 0));
      check_val("overflow",  overflow,          m_ovf);
   endtask

   task automatic idle(input int n);
      push_if.din_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic push_byte(input logic [7:0] b);
      push_if.din       = b;
      push_if.din_valid = 1'b1;
      step();
      push_if.din_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      push_if.din_valid = 1'b0;
      while ((m_rem > 0 || m_q.size() > 0) && k < 20 * FRAME) begin
         step();
         k++;
      end
      check_val("drain_done", (m_rem > 0 || m_q.size() > 0), 0);
   endtask

   task automatic busy_len(input string tag, input int exp_len);
      int k;
      k = 0;
      while (busy && k < 3 * FRAME) begin
         step();
         k++;
      end
      check_val(tag, k, exp_len);
   endtask

   initial begin
      int cnt15;
      push_if.din       = '0;
      push_if.din_valid = 1'b0;
      reset = 1'b1;
      repeat (3) step();
      check_val("rst_tx", uart_tx, 1);
      check_val("rst_ready", push_if.din_ready, 1);
      check_val("rst_level", level, 0);
      reset = 1'b0;
      idle(5);

      // Single byte: start bit on the edge after acceptance, busy for one frame.
      push_byte(8'h55);
      step();
      check_val("t1_fall", uart_tx, 0);
      busy_len("t1_busy_len", FRAME);
      idle(20);

      push_byte(8'h41);
      push_byte(8'h42);
      check_val("t2_fall", uart_tx, 0);
      busy_len("t2_busy_len", 2 * FRAME);
      idle(20);

      for (int i = 0; i < 17; i++) push_byte(8'(i));
      check_val("t3_full_level", level, 16);
      check_val("t3_full_ready", push_if.din_ready, 0);
      push_byte(8'h11);
      check_val("t3_ovf", overflow, 1);
      check_val("t3_ovf_level", level, 16);

      // Held push at full: exactly one cycle at level 15 across a frame boundary.
      push_if.din       = 8'hEE;
      push_if.din_valid = 1'b1;
      cnt15 = 0;
      repeat (FRAME) begin
         step();
         if (level != 5'd16) cnt15++;
      end
      push_if.din_valid = 1'b0;
      check_val("t4_dip", cnt15, 1);
      drain();
      check_val("t4_ovf_sticky", overflow, 1);
      idle(10);

      push_byte(8'hA3);
      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      idle(4 * DIV);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("t5_tx", uart_tx, 1);
      check_val("t5_level", level, 0);
      check_val("t5_busy", busy, 0);
      check_val("t5_ovf", overflow, 0);
      idle(2 * FRAME);
      check_val("t5_quiet", busy, 0);
      push_byte(8'h0F);
      step();
      check_val("t5_fall", uart_tx, 0);
      drain();
      idle(10);

      // Push lands on the stop-bit wrap edge that pops the only queued byte.
      push_byte(8'h11);
      push_byte(8'h22);
      idle(FRAME - 1);
      push_byte(8'h33);
      check_val("t6_level", level, 1);
      drain();
      idle(10);

      for (int b = 0; b < 12; b++) begin
         if ($urandom_range(0, 7) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
         repeat ($urandom_range(0, 6)) begin
            push_if.din       = 8'($urandom);
            push_if.din_valid = $urandom_range(0, 1) == 1;
            step();
         end
         idle($urandom_range(0, 2 * FRAME));
      end
      drain();
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
